plru_victim_ctrl: RTL and testbench

//   Replacement-side companion to the 8-way tree-PLRU state updater. Keeps one 7-bit PLRU

---
 rtl/plru_pkg.sv | 38 +++
 rtl/plru_tree_walk.sv | 22 ++
 rtl/plru_victim_ctrl.sv | 121 ++++++++++++
 tb/tb_plru_victim_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// plru_pkg: shared types and tree helpers for the 8-way tree-PLRU victim controller.
`default_nettype none

package plru_pkg;

  localparam int PLRU_WAYS  = 8;
  localparam int PLRU_NODES = 7;

  typedef logic [PLRU_NODES-1:0] plru_state_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WAIT_FILL = 2'd2
  } victim_fsm_e;

  // Point every node on the path to `way` away from it, making it MRU.
  function automatic plru_state_t plru_touch(plru_state_t state, logic [2:0] way);
    plru_state_t s;
    s    = state;
    s[6] = ~way[2];
    if (way[2]) s[5] = ~way[1];
    else        s[4] = ~way[1];
    s[{1'b0, way[2:1]}] = ~way[0];
    return s;
  endfunction

  function automatic logic [2:0] plru_victim(plru_state_t state);
    logic [2:0] v;
    v[2] = state[6];
    v[1] = v[2] ? state[5] : state[4];
    v[0] = state[{1'b0, v[2:1]}];
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plru_tree_walk.sv
// plru_tree_walk: PLRU tree to victim way, with an invalid line taking priority.
`default_nettype none

module plru_tree_walk
  import plru_pkg::*;
(
  input  plru_state_t          state_i,
  input  logic [PLRU_WAYS-1:0] vmap_i,
  output logic [2:0]           way_o
);

  // Descending scan so the lowest-index invalid way is the last one written.
  always_comb begin
    way_o = plru_victim(state_i);
    for (int i = PLRU_WAYS - 1; i >= 0; i--) begin
      if (!vmap_i[i]) way_o = i[2:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/plru_victim_ctrl.sv
// plru_victim_ctrl: per-set 8-way tree-PLRU state, hit updates and victim reservation
// until refill completes.
`default_nettype none

module plru_victim_ctrl
  import plru_pkg::*;
#(
  parameter  int NUM_SETS = 64,
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 access_valid_i,
  input  logic [SET_W-1:0]     access_set_i,
  input  logic [2:0]           access_way_i,
  input  logic                 victim_req_valid_i,
  input  logic [SET_W-1:0]     victim_req_set_i,
  input  logic [PLRU_WAYS-1:0] victim_req_vmap_i,
  output logic                 victim_req_ready_o,
  output logic                 victim_resp_valid_o,
  output logic [2:0]           victim_resp_way_o,
  input  logic                 victim_resp_ready_i,
  input  logic                 fill_done_i,
  output logic                 busy_o
);

  plru_state_t tree_q [NUM_SETS];
  plru_state_t tree_d [NUM_SETS];

  victim_fsm_e      state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [2:0]       resp_way_q;
  logic [SET_W-1:0] rsv_set_q;
  logic             busy_q;

  logic             fill_fire;
  plru_state_t      req_tree;
  logic [2:0]       victim_way;

  assign fill_fire = (state_q == WAIT_FILL) && fill_done_i;

  // Hit first, fill on top, so the fill owns any node both paths share.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      tree_d[s] = tree_q[s];
      if (access_valid_i && (access_set_i == SET_W'(s)))
        tree_d[s] = plru_touch(tree_d[s], access_way_i);
      if (fill_fire && (rsv_set_q == SET_W'(s)))
        tree_d[s] = plru_touch(tree_d[s], resp_way_q);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= tree_d[s];
    end
  end

  // Victim sees a hit landing on the same set in the same cycle.
  always_comb begin
    req_tree = tree_q[victim_req_set_i];
    if (access_valid_i && (access_set_i == victim_req_set_i))
      req_tree = plru_touch(req_tree, access_way_i);
  end

  plru_tree_walk u_walk (
    .state_i (req_tree),
    .vmap_i  (victim_req_vmap_i),
    .way_o   (victim_way)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      rsv_set_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (victim_req_valid_i && req_ready_q) begin
            rsv_set_q    <= victim_req_set_i;
            resp_way_q   <= victim_way;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (victim_resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= WAIT_FILL;
          end
        end
        WAIT_FILL: begin
          if (fill_done_i) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign victim_req_ready_o  = req_ready_q;
  assign victim_resp_valid_o = resp_valid_q;
  assign victim_resp_way_o   = resp_way_q;
  assign busy_o              = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_ctrl.sv
// tb_plru_victim_ctrl: directed vector table plus hand-written corner sequences.
`default_nettype none

module tb_plru_victim_ctrl;

  logic       clk_i;
  logic       rstn_i;
  logic       access_valid_i;
  logic [5:0] access_set_i;
  logic [2:0] access_way_i;
  logic       victim_req_valid_i;
  logic [5:0] victim_req_set_i;
  logic [7:0] victim_req_vmap_i;
  logic       victim_req_ready_o;
  logic       victim_resp_valid_o;
  logic [2:0] victim_resp_way_o;
  logic       victim_resp_ready_i;
  logic       fill_done_i;
  logic       busy_o;

  int n_cmp;
  int n_fail;

  plru_victim_ctrl #(.NUM_SETS(64)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .access_valid_i      (access_valid_i),
    .access_set_i        (access_set_i),
    .access_way_i        (access_way_i),
    .victim_req_valid_i  (victim_req_valid_i),
    .victim_req_set_i    (victim_req_set_i),
    .victim_req_vmap_i   (victim_req_vmap_i),
    .victim_req_ready_o  (victim_req_ready_o),
    .victim_resp_valid_o (victim_resp_valid_o),
    .victim_resp_way_o   (victim_resp_way_o),
    .victim_resp_ready_i (victim_resp_ready_i),
    .fill_done_i         (fill_done_i),
    .busy_o              (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [5:0] set;
    logic [7:0] vmap;
    logic       hit_en;
    logic [5:0] hit_set;
    logic [2:0] hit_way;
    logic [2:0] exp_way;
    logic [6:0] exp_tree;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (victim_req_ready_o !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) chk({name, "_ready_timeout"}, 32'(victim_req_ready_o), 32'd1);
  endtask

  // Full request / response / fill transaction with an optional same-cycle hit.
  task automatic txn(input logic [5:0] set, input logic [7:0] vmap, input logic hit_en,
                     input logic [5:0] hit_set, input logic [2:0] hit_way,
                     input logic [2:0] exp_way, input string name);
    wait_ready(name);
    victim_req_valid_i = 1'b1;
    victim_req_set_i   = set;
    victim_req_vmap_i  = vmap;
    access_valid_i     = hit_en;
    access_set_i       = hit_set;
    access_way_i       = hit_way;
    tick();
    victim_req_valid_i = 1'b0;
    access_valid_i     = 1'b0;
    chk({name, "_valid"}, 32'(victim_resp_valid_o), 32'd1);
    chk({name, "_way"},   32'(victim_resp_way_o),   32'(exp_way));
    victim_resp_ready_i = 1'b1;
    tick();
    victim_resp_ready_i = 1'b0;
    chk({name, "_valid_drop"}, 32'(victim_resp_valid_o), 32'd0);
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    chk({name, "_ready_after_fill"}, 32'(victim_req_ready_o), 32'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{6'd3,  8'hFF, 1'b0, 6'd0,  3'd0, 3'd0, 7'b1010001};
    vecs[1] = '{6'd3,  8'hFF, 1'b0, 6'd0,  3'd0, 3'd4, 7'b0110101};
    vecs[2] = '{6'd3,  8'hFF, 1'b0, 6'd0,  3'd0, 3'd2, 7'b1100111};
    vecs[3] = '{6'd3,  8'hFF, 1'b0, 6'd0,  3'd0, 3'd6, 7'b0001111};
    vecs[4] = '{6'd7,  8'hEB, 1'b0, 6'd0,  3'd0, 3'd2, 7'b1000010};
    vecs[5] = '{6'd9,  8'hFF, 1'b1, 6'd9,  3'd0, 3'd4, 7'b0110101};
    vecs[6] = '{6'd10, 8'h7F, 1'b0, 6'd0,  3'd0, 3'd7, 7'b0000000};
    vecs[7] = '{6'd11, 8'hFE, 1'b0, 6'd0,  3'd0, 3'd0, 7'b1010001};
    vecs[8] = '{6'd12, 8'hFF, 1'b1, 6'd13, 3'd0, 3'd0, 7'b1010001};

    rstn_i              = 1'b0;
    access_valid_i      = 1'b0;
    access_set_i        = '0;
    access_way_i        = '0;
    victim_req_valid_i  = 1'b0;
    victim_req_set_i    = '0;
    victim_req_vmap_i   = '0;
    victim_resp_ready_i = 1'b0;
    fill_done_i         = 1'b0;

    tick();
    tick();
    chk("rst_req_ready",  32'(victim_req_ready_o),  32'd0);
    chk("rst_resp_valid", 32'(victim_resp_valid_o), 32'd0);
    chk("rst_resp_way",   32'(victim_resp_way_o),   32'd0);
    chk("rst_busy",       32'(busy_o),              32'd0);
    chk("rst_tree3",      32'(dut.tree_q[3]),       32'd0);
    rstn_i = 1'b1;
    tick();
    tick();
    chk("idle_req_ready", 32'(victim_req_ready_o), 32'd1);

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].set, vecs[i].vmap, vecs[i].hit_en, vecs[i].hit_set, vecs[i].hit_way,
          vecs[i].exp_way, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tree", i), 32'(dut.tree_q[vecs[i].set]), 32'(vecs[i].exp_tree));
    end

    // Hits to set 5 in way order leave an all-zero tree; each lands one cycle later.
    for (int w = 0; w < 8; w++) begin
      access_valid_i = 1'b1;
      access_set_i   = 6'd5;
      access_way_i   = 3'(w);
      tick();
      if (w == 0) chk("hit_latency_tree5", 32'(dut.tree_q[5]), 32'b1010001);
    end
    access_valid_i = 1'b0;
    chk("hits_all_tree5", 32'(dut.tree_q[5]), 32'd0);
    txn(6'd5, 8'hFF, 1'b0, 6'd0, 3'd0, 3'd0, "set5_first");
    access_valid_i = 1'b1;
    access_set_i   = 6'd5;
    access_way_i   = 3'd0;
    tick();
    access_valid_i = 1'b0;
    txn(6'd5, 8'hFF, 1'b0, 6'd0, 3'd0, 3'd4, "set5_after_hit0");

    // Backpressured response; a second request waits until after fill_done.
    wait_ready("stall");
    victim_req_valid_i = 1'b1;
    victim_req_set_i   = 6'd20;
    victim_req_vmap_i  = 8'hFF;
    tick();
    victim_req_set_i = 6'd21;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), 32'(victim_resp_valid_o), 32'd1);
      chk($sformatf("stall%0d_way", c),   32'(victim_resp_way_o),   32'd0);
      chk($sformatf("stall%0d_ready", c), 32'(victim_req_ready_o),  32'd0);
      chk($sformatf("stall%0d_busy", c),  32'(busy_o),              32'd1);
      tick();
    end
    victim_resp_ready_i = 1'b1;
    tick();
    victim_resp_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("wfill%0d_ready", c), 32'(victim_req_ready_o), 32'd0);
      chk($sformatf("wfill%0d_busy", c),  32'(busy_o),             32'd1);
      tick();
    end
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    chk("stall_ready_after_fill", 32'(victim_req_ready_o), 32'd1);
    chk("stall_tree20", 32'(dut.tree_q[20]), 32'b1010001);
    tick();
    victim_req_valid_i = 1'b0;
    chk("second_req_valid", 32'(victim_resp_valid_o), 32'd1);
    chk("second_req_way",   32'(victim_resp_way_o),   32'd0);
    victim_resp_ready_i = 1'b1;
    tick();
    victim_resp_ready_i = 1'b0;
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    chk("second_tree21", 32'(dut.tree_q[21]), 32'b1010001);

    // Hit way 6 and fill of way 0 on set 30 in the same cycle: fill wins shared nodes.
    wait_ready("merge");
    victim_req_valid_i = 1'b1;
    victim_req_set_i   = 6'd30;
    victim_req_vmap_i  = 8'hFF;
    tick();
    victim_req_valid_i = 1'b0;
    chk("merge_way", 32'(victim_resp_way_o), 32'd0);
    victim_resp_ready_i = 1'b1;
    tick();
    victim_resp_ready_i = 1'b0;
    access_valid_i = 1'b1;
    access_set_i   = 6'd30;
    access_way_i   = 3'd6;
    fill_done_i    = 1'b1;
    tick();
    access_valid_i = 1'b0;
    fill_done_i    = 1'b0;
    chk("merge_tree30", 32'(dut.tree_q[30]), 32'b1011001);

    // fill_done while idle must not touch any tree.
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    chk("idle_fill_tree30", 32'(dut.tree_q[30]), 32'b1011001);
    chk("idle_fill_busy",   32'(busy_o),         32'd0);

    // Asynchronous reset while a response is pending.
    wait_ready("arst");
    victim_req_valid_i = 1'b1;
    victim_req_set_i   = 6'd30;
    victim_req_vmap_i  = 8'hFF;
    tick();
    victim_req_valid_i = 1'b0;
    chk("arst_pre_valid", 32'(victim_resp_valid_o), 32'd1);
    chk("arst_pre_way",   32'(victim_resp_way_o),   32'd4);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_valid", 32'(victim_resp_valid_o), 32'd0);
    chk("arst_busy",  32'(busy_o),              32'd0);
    chk("arst_ready", 32'(victim_req_ready_o),  32'd0);
    chk("arst_tree30", 32'(dut.tree_q[30]),     32'd0);
    chk("arst_tree3",  32'(dut.tree_q[3]),      32'd0);
    tick();
    rstn_i = 1'b1;
    txn(6'd3, 8'hFF, 1'b0, 6'd0, 3'd0, 3'd0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
